button_event_detector: RTL and testbench
========================================

Name: button_event_detector

Overview:
- Sits directly downstream of the debouncer and consumes its clean, active-high level output.
- Converts that level into single-cycle event pulses: press, release, short press, long press and auto-repeat while held.
- Also provides a held-state level and a running press counter.
- Feeds UI/control logic that needs discrete button events instead of levels.

Parameters:
- LONG_CYCLES, 16: hold threshold in clock cycles for a long press; must be ≥ 2.
- REPEAT_CYCLES, 8: auto-repeat period in clock cycles while in HELD; must be ≥ 1.
- REPEAT_EN, 1: 1 enables repeat_o; 0 ties it to 0.
- CNT_W, 8: width of press_cnt_o.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- debounced_i  input  1  debounced button level, 1 = pressed; already synchronous to clock.
- clear_i  input  1  synchronous clear of press_cnt_o.
- press_o  output  1  one-cycle pulse on press detection.
- release_o  output  1  one-cycle pulse on release.
- short_o  output  1  one-cycle pulse on release of a short press.
- long_o  output  1  one-cycle pulse when the hold threshold is reached.
- repeat_o  output  1  one-cycle periodic pulse while HELD.
- held_o  output  1  level, high while in HELD.
- press_cnt_o  output  CNT_W  number of presses; wraps.

Behaviour:
- One clock; reset is synchronous and active-low.
- All outputs are registered.
- Notation: "after edge n" means the value visible in the cycle following rising edge n.

Reset:
- resetn = 0 sampled at an edge: state = IDLE, hold_cnt = 0, rep_cnt = 0, all outputs 0, press_cnt_o = 0.
- Reset takes priority over everything.
- Reset mid-press aborts silently; no release_o is generated.

FSM states: IDLE, PRESSED, HELD. Pulse outputs default to 0 every cycle.

IDLE:
- debounced_i = 1 at edge k: go to PRESSED, hold_cnt = 0, press_o = 1 after edge k, press_cnt_o += 1.
- IDLE is level-triggered, so a button still high when reset releases produces press_o after the first edge.

PRESSED, at each edge:
- debounced_i = 0: go to IDLE, release_o = 1 and short_o = 1.
- Else if hold_cnt == LONG_CYCLES-1: go to HELD, long_o = 1, rep_cnt = 0.
- Else: hold_cnt += 1.
- Net timing: long_o appears after edge k+LONG_CYCLES.
- A low input at edge k+LONG_CYCLES gives a short release; release has priority over the threshold.

HELD, at each edge:
- debounced_i = 0: go to IDLE, release_o = 1, short_o = 0.
- Else if rep_cnt == REPEAT_CYCLES-1: repeat_o = REPEAT_EN, rep_cnt = 0.
- Else: rep_cnt += 1.
- Repeat pulses appear after edges k+LONG_CYCLES+m·REPEAT_CYCLES, m ≥ 1.
- With REPEAT_CYCLES = 1, repeat_o is high every cycle in HELD after the entry cycle.

held_o:
- 1 while state = HELD, including the cycle in which long_o pulses.
- 0 from the cycle release_o pulses.

Counters:
- hold_cnt is $clog2(LONG_CYCLES) bits; rep_cnt is max(1, $clog2(REPEAT_CYCLES)) bits.
- Neither counter ever exceeds its terminal value.

press_cnt_o:
- Wraps 2^CNT_W-1 → 0.
- clear_i alone → 0.
- clear_i together with a press in the same cycle → 1 (the press counts after the clear).

Mutual exclusion:
- press_o and release_o are never high in the same cycle.
- long_o and short_o are never high in the same press.

Test Plan:
- Default parameters. debounced_i high for edges 0–4, low at edge 5 → press_o after edge 0; release_o and short_o after edge 5; long_o, repeat_o and held_o stay 0; press_cnt_o = 1.
- Input high for edges 0–39, low at edge 40 → long_o and held_o rise after edge 16; repeat_o after edges 24 and 32 only; release_o after edge 40 with short_o = 0; held_o = 0 after edge 40.
- Boundary: input low at edge 16 → short_o = 1 and no long_o. Repeat with input low at edge 17 → long_o after edge 16, release_o after edge 17, short_o = 0.
- Counter cases:
  - press_cnt_o = 5, then clear_i with a press in the same cycle → 1.
  - clear_i alone → 0.
  - 256 presses from 0 → wraps to 0.
- Reset case: input held high in HELD, resetn = 0 for 2 edges → all outputs 0, no release_o. After resetn = 1 with input still high → press_o after the first edge, press_cnt_o = 1, long_o 16 edges later.
- REPEAT_EN = 0 with REPEAT_CYCLES = 1 → repeat_o stays 0 during a 40-cycle hold. REPEAT_EN = 1 with REPEAT_CYCLES = 1 → repeat_o every cycle from edge 17 until release.

Source files
------------

// File: rtl/button_event_detector.sv
// Turns a debounced button level into press/release/short/long/repeat event
// pulses, a held level and a wrapping press counter. All outputs are registered.
module button_event_detector #(
  parameter int LONG_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 8,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             debounced_i,
  input  logic             clear_i,
  output logic             press_o,
  output logic             release_o,
  output logic             short_o,
  output logic             long_o,
  output logic             repeat_o,
  output logic             held_o,
  output logic [CNT_W-1:0] press_cnt_o
);

  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_HELD    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [RW-1:0]    rep_cnt_q, rep_cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    // A clear in the same cycle as a press is applied first, so the press counts.
    cnt_d      = clear_i ? {CNT_W{1'b0}} : cnt_q;

    case (state_q)
      S_IDLE: begin
        if (debounced_i) begin
          state_d    = S_PRESSED;
          hold_cnt_d = {HW{1'b0}};
          press_d    = 1'b1;
          cnt_d      = cnt_d + CNT_W'(1'b1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRESSED: begin
        if (!debounced_i) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
          short_d   = 1'b1;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = S_HELD;
          long_d    = 1'b1;
          rep_cnt_d = {RW{1'b0}};
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1'b1);
        end
      end
      S_HELD: begin
        if (!debounced_i) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
        end else if (rep_cnt_q == REP_LAST) begin
          repeat_d  = REPEAT_EN;
          rep_cnt_d = {RW{1'b0}};
        end else begin
          rep_cnt_d = rep_cnt_q + RW'(1'b1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    held_d = (state_d == S_HELD);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= {HW{1'b0}};
      rep_cnt_q  <= {RW{1'b0}};
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      held_q     <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      short_q    <= short_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      held_q     <= held_d;
      cnt_q      <= cnt_d;
    end
  end

  assign press_o     = press_q;
  assign release_o   = release_q;
  assign short_o     = short_q;
  assign long_o      = long_q;
  assign repeat_o    = repeat_q;
  assign held_o      = held_q;
  assign press_cnt_o = cnt_q;

endmodule

// File: tb/tb_button_event_detector.sv
// Bench for button_event_detector: three parameterisations driven in lockstep,
// checked against a press-age reference model plus constant vector tables.
module tb_button_event_detector;

  localparam int L = 16;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       deb = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] press_w, release_w, short_w, long_w, repeat_w, held_w;
  logic [7:0] cnt_w [3];

  int n_vec = 0;
  int n_err = 0;

  // reference model state: press age in edges, per instance
  bit       m_pr [3];
  int       m_j [3];
  bit [7:0] m_cnt [3];
  bit [5:0] m_pulse [3];
  int       par_r [3];
  bit       par_en [3];

  always #5 clock = ~clock;

  button_event_detector #(.LONG_CYCLES(16), .REPEAT_CYCLES(8), .REPEAT_EN(1'b1), .CNT_W(8)) u_dut0 (
    .clock(clock), .resetn(resetn), .debounced_i(deb), .clear_i(clr),
    .press_o(press_w[0]), .release_o(release_w[0]), .short_o(short_w[0]), .long_o(long_w[0]),
    .repeat_o(repeat_w[0]), .held_o(held_w[0]), .press_cnt_o(cnt_w[0]));

  button_event_detector #(.LONG_CYCLES(16), .REPEAT_CYCLES(1), .REPEAT_EN(1'b0), .CNT_W(8)) u_dut1 (
    .clock(clock), .resetn(resetn), .debounced_i(deb), .clear_i(clr),
    .press_o(press_w[1]), .release_o(release_w[1]), .short_o(short_w[1]), .long_o(long_w[1]),
    .repeat_o(repeat_w[1]), .held_o(held_w[1]), .press_cnt_o(cnt_w[1]));

  button_event_detector #(.LONG_CYCLES(16), .REPEAT_CYCLES(1), .REPEAT_EN(1'b1), .CNT_W(8)) u_dut2 (
    .clock(clock), .resetn(resetn), .debounced_i(deb), .clear_i(clr),
    .press_o(press_w[2]), .release_o(release_w[2]), .short_o(short_w[2]), .long_o(long_w[2]),
    .repeat_o(repeat_w[2]), .held_o(held_w[2]), .press_cnt_o(cnt_w[2]));

  typedef struct {
    bit       rst_n;
    bit       d;
    bit       c;
    bit [5:0] exp_p;   // {press, release, short, long, repeat, held}
    bit [7:0] exp_cnt;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(bit rst_n, bit d, bit c, bit [5:0] p, bit [7:0] n);
    vec_t v;
    v.rst_n = rst_n; v.d = d; v.c = c; v.exp_p = p; v.exp_cnt = n;
    return v;
  endfunction

  function automatic logic [13:0] act(int i);
    return {press_w[i], release_w[i], short_w[i], long_w[i], repeat_w[i], held_w[i], cnt_w[i]};
  endfunction

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit pr, rl, sh, lg, rp, hd;
      pr = 1'b0; rl = 1'b0; sh = 1'b0; lg = 1'b0; rp = 1'b0; hd = 1'b0;
      if (!resetn) begin
        m_pr[i] = 1'b0; m_j[i] = 0; m_cnt[i] = 8'd0;
      end else if (!m_pr[i]) begin
        if (deb) begin
          m_pr[i] = 1'b1; m_j[i] = 0; pr = 1'b1;
          m_cnt[i] = (clr ? 8'd0 : m_cnt[i]) + 8'd1;
        end else if (clr) begin
          m_cnt[i] = 8'd0;
        end
      end else begin
        m_j[i]++;
        if (clr) m_cnt[i] = 8'd0;
        if (!deb) begin
          rl = 1'b1; sh = (m_j[i] <= L); m_pr[i] = 1'b0;
        end else begin
          lg = (m_j[i] == L);
          rp = par_en[i] && (m_j[i] > L) && (((m_j[i] - L) % par_r[i]) == 0);
          hd = (m_j[i] >= L);
        end
      end
      m_pulse[i] = {pr, rl, sh, lg, rp, hd};
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("model_dut%0d", i), 32'(act(i)), 32'({m_pulse[i], m_cnt[i]}));
  endtask

  // high for n_high edges (edge 0 = press), low at edge n_high, then one idle edge
  task automatic run_press(input int n_high, output int long_at, output int rel_at,
                           output bit short_seen, output int n_rep0, output int n_rep1,
                           output int n_rep2);
    long_at = -1; rel_at = -1; short_seen = 1'b0; n_rep0 = 0; n_rep1 = 0; n_rep2 = 0;
    for (int e = 0; e <= n_high; e++) begin
      deb = (e < n_high);
      tick();
      if (long_w[0]) long_at = e;
      if (release_w[0]) begin rel_at = e; short_seen = short_w[0]; end
      n_rep0 += int'(repeat_w[0]);
      n_rep1 += int'(repeat_w[1]);
      n_rep2 += int'(repeat_w[2]);
    end
    deb = 1'b0;
    tick();
  endtask

  initial begin
    int la, ra, r0, r1, r2;
    bit sh;
    par_r[0] = 8; par_r[1] = 1; par_r[2] = 1;
    par_en[0] = 1'b1; par_en[1] = 1'b0; par_en[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_pr[i] = 1'b0; m_j[i] = 0; m_cnt[i] = 8'd0; m_pulse[i] = 6'd0;
    end

    // reset, then a 5-edge short press
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000000, 8'd0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000000, 8'd0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 6'b100000, 8'd1));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1'b1, 1'b1, 1'b0, 6'b000000, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 6'b011000, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 6'b000000, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 6'b000000, 8'd0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 6'b100000, 8'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 6'b011000, 8'd1));
    foreach (tbl[k]) begin
      resetn = tbl[k].rst_n; deb = tbl[k].d; clr = tbl[k].c;
      tick();
      chk($sformatf("table[%0d]", k), 32'(act(0)), 32'({tbl[k].exp_p, tbl[k].exp_cnt}));
    end
    clr = 1'b0; deb = 1'b0;
    tick();

    run_press(40, la, ra, sh, r0, r1, r2);
    chk("long_hold_long_at", la, 16);
    chk("long_hold_rel_at", ra, 40);
    chk("long_hold_short", 32'(sh), 32'd0);
    chk("long_hold_repeats", r0, 2);
    chk("rep_en0_repeats", r1, 0);
    chk("rep1_repeats", r2, 23);

    run_press(16, la, ra, sh, r0, r1, r2);
    chk("edge16_short", 32'(sh), 32'd1);
    chk("edge16_no_long", la, -1);
    chk("edge16_rel_at", ra, 16);

    run_press(17, la, ra, sh, r0, r1, r2);
    chk("edge17_long_at", la, 16);
    chk("edge17_rel_at", ra, 17);
    chk("edge17_short", 32'(sh), 32'd0);

    // counter: clear, five presses, clear together with a press, clear alone
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clear_alone_a", 32'(cnt_w[0]), 32'd0);
    for (int k = 0; k < 5; k++) run_press(1, la, ra, sh, r0, r1, r2);
    chk("cnt_five", 32'(cnt_w[0]), 32'd5);
    clr = 1'b1; deb = 1'b1; tick(); clr = 1'b0;
    chk("clear_with_press", 32'(cnt_w[0]), 32'd1);
    chk("clear_with_press_pulse", 32'(press_w[0]), 32'd1);
    deb = 1'b0; tick(); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clear_alone_b", 32'(cnt_w[0]), 32'd0);
    for (int k = 0; k < 256; k++) run_press(1, la, ra, sh, r0, r1, r2);
    chk("cnt_wrap", 32'(cnt_w[0]), 32'd0);

    // reset while held: silent abort, then level-triggered re-press
    deb = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    chk("held_before_reset", 32'(held_w[0]), 32'd1);
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("reset_outputs", 32'(act(0)), 32'd0);
    end
    resetn = 1'b1;
    tick();
    chk("repress_pulse", 32'(press_w[0]), 32'd1);
    chk("repress_cnt", 32'(cnt_w[0]), 32'd1);
    la = -1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (long_w[0]) la = e;
    end
    chk("repress_long_at", la, 16);
    deb = 1'b0; tick(); tick();

    // randomized runs checked by the model every edge
    for (int s = 0; s < 120; s++) begin
      int len;
      bit lvl;
      len = $urandom_range(1, 45);
      lvl = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        deb = lvl;
        clr = ($urandom_range(0, 19) == 0);
        resetn = ($urandom_range(0, 149) != 0);
        tick();
      end
    end
    resetn = 1'b1; clr = 1'b0; deb = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
